// File: rtl/dc_motor_pkg.sv
// Shared types and helpers for the ramped DC motor PWM driver.
package dc_motor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        DEAD = 2'd3
    } motor_state_t;

    // All-ones select means full on (2^cnt_w); otherwise the select is scaled
    // up to the counter range.
    function automatic logic [31:0] target_duty(
        input logic [31:0] psw,
        input int unsigned sel_w,
        input int unsigned cnt_w
    );
        logic [31:0] all_ones;
        all_ones = (32'd1 << sel_w) - 32'd1;
        if (psw == all_ones)
            return 32'd1 << cnt_w;
        return psw << (cnt_w - sel_w);
    endfunction

endpackage

// File: rtl/dc_motor_pwm_gen.sv
// Free-running PWM counter with period-boundary duty latch and registered compare.
module dc_motor_pwm_gen
    import dc_motor_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [CNT_W:0] duty_cur,
    input  logic           force_off,
    output logic [CNT_W:0] duty_act,
    output logic           pdcm
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            duty_act <= '0;
            pdcm     <= 1'b0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            // Latching only at the last count keeps every period whole.
            if (cnt == '1)
                duty_act <= duty_cur;
            pdcm <= !force_off && ({1'b0, cnt} < duty_act);
        end
    end

endmodule

// File: rtl/dc_motor_pwm_ramp.sv
// DC motor PWM driver with soft start/stop ramping, enable and dead-timed reversal.
module dc_motor_pwm_ramp
    import dc_motor_pkg::*;
#(
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned RAMP_DIV = 16,
    parameter int unsigned DEAD_CYC = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] psw,
    input  logic             dir_req,
    output logic             pdcm,
    output logic             pdir,
    output logic             at_speed,
    output logic             busy
);

    localparam int unsigned TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC - 1);

    motor_state_t      state;
    logic [CNT_W:0]    duty_cur;
    logic [CNT_W:0]    duty_act;
    logic [CNT_W:0]    psw_tgt;
    logic [CNT_W:0]    tgt;
    logic [TICK_W-1:0] tick;
    logic [DEAD_W-1:0] dead_cnt;
    logic              ramp_step;
    logic              force_off;

    always_comb begin
        psw_tgt   = (CNT_W+1)'(target_duty(32'(psw), SEL_W, CNT_W));
        tgt       = (state == RUN) ? psw_tgt : '0;
        ramp_step = (tick == TICK_LAST);
        force_off = (state == DEAD);
    end

    // One LSB per tick toward a target that may move at any time, so a
    // redirected ramp never overshoots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick     <= '0;
            duty_cur <= '0;
        end else begin
            tick <= ramp_step ? '0 : tick + TICK_W'(1);
            if (ramp_step) begin
                if (duty_cur < tgt)
                    duty_cur <= duty_cur + (CNT_W+1)'(1);
                else if (duty_cur > tgt)
                    duty_cur <= duty_cur - (CNT_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pdir     <= 1'b0;
            busy     <= 1'b0;
            at_speed <= 1'b0;
            dead_cnt <= '0;
        end else begin
            at_speed <= (state == RUN) && (duty_cur == tgt) && (duty_act == duty_cur);
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (en) begin
                        pdir  <= dir_req;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en || (dir_req != pdir)) begin
                        state <= STOP;
                        busy  <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                STOP: begin
                    busy <= 1'b1;
                    // Wait for the applied duty too, so the bridge is really off.
                    if ((duty_cur == '0) && (duty_act == '0)) begin
                        dead_cnt <= DEAD_LOAD;
                        state    <= DEAD;
                    end
                end
                DEAD: begin
                    if (dead_cnt == '0) begin
                        busy <= 1'b0;
                        if (en) begin
                            pdir  <= dir_req;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        busy     <= 1'b1;
                        dead_cnt <= dead_cnt - DEAD_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    dc_motor_pwm_gen #(
        .CNT_W(CNT_W)
    ) u_pwm (
        .clk      (clk),
        .rst      (rst),
        .duty_cur (duty_cur),
        .force_off(force_off),
        .duty_act (duty_act),
        .pdcm     (pdcm)
    );

endmodule
